// File: rtl/axil_pkg.sv
// Shared definitions for the AXI-lite vector RAM: response codes and write-FSM states.
package axil_pkg;

    localparam logic RESP_OKAY   = 1'b0;
    localparam logic RESP_SLVERR = 1'b1;

    typedef enum logic [1:0] {
        WIdle,
        WAddr,
        WData,
        WResp
    } wr_state_e;

endpackage

// File: rtl/axil_ram_wr_ctrl.sv
// Write-side controller: AW/W holding registers, write FSM and B channel.
// Emits a one-cycle strobe on the edge that enters WResp when the address is in range.
module axil_ram_wr_ctrl
    import axil_pkg::*;
#(
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic                  wavalid_i,
    output logic                  waready_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic                  wresp_o,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] we_addr_o,
    output logic [DATA_WIDTH-1:0] we_data_o
);

    localparam logic [ADDR_WIDTH:0] DepthLim = (ADDR_WIDTH + 1)'(DEPTH);

    wr_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  wresp_q, wresp_d;
    logic                  aw_hs, w_hs, finish, in_range;

    always_comb begin
        waready_o = (state_q == WIdle) || (state_q == WData);
        wready_o  = (state_q == WIdle) || (state_q == WAddr);
        bvalid_o  = (state_q == WResp);
        wresp_o   = wresp_q;

        aw_hs = wavalid_i && waready_o;
        w_hs  = wvalid_i && wready_o;

        // Bypass the holding register when the beat arrives on the completing edge.
        addr_d   = aw_hs ? waddr_i : addr_q;
        data_d   = w_hs ? wdata_i : data_q;
        in_range = {1'b0, addr_d} < DepthLim;

        state_d = state_q;
        finish  = 1'b0;
        unique case (state_q)
            WIdle: begin
                if (aw_hs && w_hs) begin
                    state_d = WResp;
                    finish  = 1'b1;
                end else if (aw_hs) begin
                    state_d = WAddr;
                end else if (w_hs) begin
                    state_d = WData;
                end
            end
            WAddr: begin
                if (w_hs) begin
                    state_d = WResp;
                    finish  = 1'b1;
                end
            end
            WData: begin
                if (aw_hs) begin
                    state_d = WResp;
                    finish  = 1'b1;
                end
            end
            WResp: begin
                if (bready_i) begin
                    state_d = WIdle;
                end
            end
        endcase

        wresp_d = wresp_q;
        if (finish) begin
            wresp_d = in_range ? RESP_OKAY : RESP_SLVERR;
        end

        we_o      = finish && in_range;
        we_addr_o = addr_d;
        we_data_o = data_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= WIdle;
            addr_q  <= '0;
            data_q  <= '0;
            wresp_q <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wresp_q <= wresp_d;
        end
    end

endmodule

// File: rtl/axil_vec_ram.sv
// AXI-lite responder word memory standing in for DDR behind the vector-add master port.
// Single-beat writes and 1-cycle-latency reads; counts OKAY writes since reset.
module axil_vec_ram
    import axil_pkg::*;
#(
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic                  wavalid_i,
    output logic                  waready_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic                  wresp_o,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [CNT_WIDTH-1:0]  wr_count_o
);

    localparam int unsigned         IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DepthLim = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  we;
    logic [ADDR_WIDTH-1:0] we_addr;
    logic [DATA_WIDTH-1:0] we_data;

    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  ar_hs, rd_in_range;
    logic [IdxW-1:0]       ridx;

    axil_ram_wr_ctrl #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wr_ctrl (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .waddr_i   (waddr_i),
        .wavalid_i (wavalid_i),
        .waready_o (waready_o),
        .wdata_i   (wdata_i),
        .wvalid_i  (wvalid_i),
        .wready_o  (wready_o),
        .wresp_o   (wresp_o),
        .bvalid_o  (bvalid_o),
        .bready_i  (bready_i),
        .we_o      (we),
        .we_addr_o (we_addr),
        .we_data_o (we_data)
    );

    // Array is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_q[IdxW'(we_addr)] <= we_data;
        end
    end

    always_comb begin
        arready_o   = !rvalid_q || rready_i;
        ar_hs       = arvalid_i && arready_o;
        ridx        = IdxW'(raddr_i);
        rd_in_range = {1'b0, raddr_i} < DepthLim;

        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        // The array read sees the pre-edge contents, so a same-edge write returns the old word.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_in_range ? mem_q[ridx] : '0;
        end else if (rready_i) begin
            rvalid_d = 1'b0;
        end

        count_d = we ? count_q + CNT_WIDTH'(1) : count_q;

        rvalid_o   = rvalid_q;
        rdata_o    = rdata_q;
        wr_count_o = count_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            count_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_axil_vec_ram.sv
// Bench for axil_vec_ram: transaction-level model checked every cycle plus directed literals.
module tb_axil_vec_ram;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 6;
    localparam int unsigned CW    = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [AW-1:0] waddr = '0;
    logic          wavalid = 1'b0;
    logic          waready;
    logic [DW-1:0] wdata = '0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic          wresp;
    logic          bvalid;
    logic          bready = 1'b1;
    logic [AW-1:0] raddr = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rready = 1'b1;
    logic [CW-1:0] wr_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axil_vec_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) u_dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .waddr_i    (waddr),
        .wavalid_i  (wavalid),
        .waready_o  (waready),
        .wdata_i    (wdata),
        .wvalid_i   (wvalid),
        .wready_o   (wready),
        .wresp_o    (wresp),
        .bvalid_o   (bvalid),
        .bready_i   (bready),
        .raddr_i    (raddr),
        .arvalid_i  (arvalid),
        .arready_o  (arready),
        .rdata_o    (rdata),
        .rvalid_o   (rvalid),
        .rready_i   (rready),
        .wr_count_o (wr_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            m_aw_held = 0, m_w_held = 0, m_bvalid = 0, m_wresp = 0;
    bit            m_rvalid = 0, m_rknown = 1;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0, m_rdata = '0;
    logic [DW-1:0] m_mem [64];
    bit            m_known [64];
    logic [CW-1:0] m_count = '0;

    initial begin
        bit aw_rdy, w_rdy, ar_rdy;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_aw_held = 0; m_w_held = 0; m_bvalid = 0; m_wresp = 0;
                m_rvalid = 0; m_rknown = 1; m_rdata = '0; m_count = '0;
            end else begin
                aw_rdy = !m_aw_held && !m_bvalid;
                w_rdy  = !m_w_held && !m_bvalid;
                ar_rdy = !m_rvalid || rready;
                if (arvalid && ar_rdy) begin
                    m_rvalid = 1;
                    if (raddr < DEPTH) begin
                        m_rknown = m_known[raddr];
                        m_rdata  = m_mem[raddr];
                    end else begin
                        m_rknown = 1;
                        m_rdata  = '0;
                    end
                end else if (m_rvalid && rready) begin
                    m_rvalid = 0;
                end
                if (m_bvalid && bready) m_bvalid = 0;
                if (wavalid && aw_rdy) begin m_aw_held = 1; m_addr = waddr; end
                if (wvalid && w_rdy) begin m_w_held = 1; m_data = wdata; end
                if (m_aw_held && m_w_held) begin
                    m_aw_held = 0; m_w_held = 0; m_bvalid = 1;
                    if (m_addr < DEPTH) begin
                        m_mem[m_addr] = m_data; m_known[m_addr] = 1;
                        m_count = m_count + 1'b1; m_wresp = 0;
                    end else begin
                        m_wresp = 1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare + beat collection ----------------
    bit            collect = 0;
    logic [DW-1:0] beats[$];

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("waready", waready, !m_aw_held && !m_bvalid);
                chk("wready", wready, !m_w_held && !m_bvalid);
                chk("bvalid", bvalid, m_bvalid);
                if (m_bvalid) chk("wresp", wresp, m_wresp);
                chk("arready", arready, !m_rvalid || rready);
                chk("rvalid", rvalid, m_rvalid);
                if (m_rvalid && m_rknown) chk("rdata", rdata, m_rdata);
                chk("wr_count", wr_count, m_count);
                if (collect && rvalid && rready) beats.push_back(rdata);
            end
        end
    end

    // ---------------- stimulus helpers (start/end at posedge+1) ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, output logic resp);
        int n;
        waddr = a; wdata = d; wavalid = 1; wvalid = 1;
        n = 0;
        while (!(waready && wready) && n < 50) begin @(negedge clk); n++; end
        if (n == 50) chk("wr_accept_timeout", 0, 1);
        step();
        wavalid = 0; wvalid = 0;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        if (n == 50) chk("wr_bvalid_timeout", 0, 1);
        resp = wresp;
        step();
    endtask

    task automatic aw_send(input logic [AW-1:0] a);
        int n;
        waddr = a; wavalid = 1;
        n = 0;
        while (!waready && n < 50) begin @(negedge clk); n++; end
        if (n == 50) chk("aw_timeout", 0, 1);
        step();
        wavalid = 0;
    endtask

    task automatic w_send(input logic [DW-1:0] d);
        int n;
        wdata = d; wvalid = 1;
        n = 0;
        while (!wready && n < 50) begin @(negedge clk); n++; end
        if (n == 50) chk("w_timeout", 0, 1);
        step();
        wvalid = 0;
    endtask

    task automatic ar_send(input logic [AW-1:0] a);
        int n;
        raddr = a; arvalid = 1;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        if (n == 50) chk("ar_timeout", 0, 1);
        step();
        arvalid = 0;
    endtask

    task automatic read_check(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                              input string name);
        ar_send(a);
        @(negedge clk);
        chk({name, "_rvalid"}, rvalid, 1);
        chk(name, rdata, exp);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic        resp;
        int          i, k;
        bit          acc;
        logic [15:0] pat;
        pat = 16'b1011_0011_1000_1101;

        #1 rst_n = 0;
        repeat (3) step();
        chk("rst_waready", waready, 1);
        chk("rst_wready", wready, 1);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_arready", arready, 1);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_wr_count", wr_count, 0);
        rst_n = 1;
        step();

        // 1: same-cycle AW+W, then read back
        wr(6'd3, 32'hDEAD_BEEF, resp);
        chk("t1_wresp", resp, 0);
        chk("t1_bvalid_one_cycle", bvalid, 0);
        chk("t1_wr_count", wr_count, 1);
        read_check(6'd3, 32'hDEAD_BEEF, "t1_rdata");

        // 2: W before AW, back-pressured B
        bready = 0;
        w_send(32'h11);
        repeat (4) step();
        aw_send(6'd5);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("t2_bvalid_held", bvalid, 1);
            chk("t2_waready_blocked", waready, 0);
            chk("t2_wready_blocked", wready, 0);
        end
        step();
        bready = 1;
        step();
        chk("t2_bvalid_cleared", bvalid, 0);
        read_check(6'd5, 32'h11, "t2_rdata");

        // 3: out-of-range writes and reads, including first address past the end
        wr(6'd40, 32'h55, resp);
        chk("t3_slverr_40", resp, 1);
        wr(6'd32, 32'h56, resp);
        chk("t3_slverr_32", resp, 1);
        chk("t3_wr_count", wr_count, 2);
        read_check(6'd40, 32'h0, "t3_oob_rdata_40");
        read_check(6'd32, 32'h0, "t3_oob_rdata_32");

        // 4: fill, stream back-to-back, then stream with rready stalls
        for (int j = 0; j < 32; j++) wr(j[AW-1:0], 32'(j * 2), resp);
        chk("t4_wr_count", wr_count, 34);
        beats.delete();
        collect = 1;
        arvalid = 1;
        for (int j = 0; j < 32; j++) begin
            raddr = j[AW-1:0];
            @(negedge clk);
            chk("t4_stream_arready", arready, 1);
            step();
        end
        arvalid = 0;
        step();
        collect = 0;
        chk("t4_stream_beats", beats.size(), 32);
        for (int j = 0; j < 32 && j < beats.size(); j++) chk("t4_stream_beat", beats[j], j * 2);

        beats.delete();
        collect = 1;
        i = 0;
        k = 0;
        while (i < 16 && k < 200) begin
            rready  = pat[k[3:0]];
            arvalid = 1;
            raddr   = 6'(i + 8);
            @(negedge clk);
            acc = arready;
            step();
            if (acc) i++;
            k++;
        end
        arvalid = 0;
        rready  = 1;
        step();
        step();
        collect = 0;
        chk("t4_stall_beats", beats.size(), 16);
        for (int j = 0; j < 16 && j < beats.size(); j++)
            chk("t4_stall_beat", beats[j], (j + 8) * 2);

        // 5: same-edge write and read of one address is read-first
        wr(6'd7, 32'h01, resp);
        waddr = 6'd7; wdata = 32'hAA; wavalid = 1; wvalid = 1;
        raddr = 6'd7; arvalid = 1;
        @(negedge clk);
        chk("t5_all_ready", {waready, wready, arready}, 3'b111);
        step();
        wavalid = 0; wvalid = 0; arvalid = 0;
        @(negedge clk);
        chk("t5_same_edge_old", rdata, 32'h01);
        chk("t5_bvalid", bvalid, 1);
        step();
        read_check(6'd7, 32'hAA, "t5_new_word");
        chk("t5_wr_count", wr_count, 36);

        // 6: asynchronous reset with an address held and a read response pending
        wr(6'd9, 32'h99, resp);
        rready = 0;
        ar_send(6'd2);
        aw_send(6'd12);
        chk("t6_pre_waready", waready, 0);
        chk("t6_pre_rvalid", rvalid, 1);
        #2 rst_n = 0;
        #1;
        chk("t6_async_waready", waready, 1);
        chk("t6_async_wready", wready, 1);
        chk("t6_async_bvalid", bvalid, 0);
        chk("t6_async_wresp", wresp, 0);
        chk("t6_async_arready", arready, 1);
        chk("t6_async_rvalid", rvalid, 0);
        chk("t6_async_rdata", rdata, 0);
        chk("t6_async_wr_count", wr_count, 0);
        step();
        rst_n  = 1;
        rready = 1;
        step();
        w_send(32'h77);
        repeat (3) step();
        chk("t6_no_stale_write", bvalid, 0);
        aw_send(6'd10);
        step();
        chk("t6_wr_count_after", wr_count, 1);
        read_check(6'd12, 32'd24, "t6_discarded_write");
        read_check(6'd10, 32'h77, "t6_post_reset_write");
        read_check(6'd9, 32'h99, "t6_array_survives");

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
